// File: rtl/f2sdram_burst_reader_if.sv
// Bus bundle for f2sdram_burst_reader: the request port, the Avalon-MM read
// channel toward the f2sdram port, and the ready/valid output stream.
// The master modport is the burst reader's view; slave is the environment's view.
interface f2sdram_burst_reader_if #(
    parameter int ADDRESS_WIDTH    = 29,
    parameter int DATA_WIDTH       = 64,
    parameter int BURSTCOUNT_WIDTH = 8,
    parameter int BYTEENABLE_WIDTH = 8,
    parameter int LENGTH_WIDTH     = 16
);
    // request side
    logic                        req_valid;
    logic                        req_ready;
    logic [ADDRESS_WIDTH-1:0]    req_address;
    logic [LENGTH_WIDTH-1:0]     req_length;
    logic                        busy;
    logic                        done;
    // Avalon-MM read channel
    logic                        waitrequest;
    logic [BURSTCOUNT_WIDTH-1:0] burstcount;
    logic [ADDRESS_WIDTH-1:0]    address;
    logic                        read;
    logic [BYTEENABLE_WIDTH-1:0] byteenable;
    logic [DATA_WIDTH-1:0]       readdata;
    logic                        readdatavalid;
    // output stream
    logic [DATA_WIDTH-1:0]       out_data;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        input  req_valid, req_address, req_length,
        input  waitrequest, readdata, readdatavalid, out_ready,
        output req_ready, busy, done,
        output burstcount, address, read, byteenable,
        output out_data, out_valid
    );

    modport slave (
        output req_valid, req_address, req_length,
        output waitrequest, readdata, readdatavalid, out_ready,
        input  req_ready, busy, done,
        input  burstcount, address, read, byteenable,
        input  out_data, out_valid
    );
endinterface

// File: rtl/f2sdram_burst_reader.sv
// Avalon-MM burst read master for the f2sdram read channel.
// Splits a linear (address, length) read into bursts of at most MAX_BURST
// words and returns the data through an internal FIFO as a ready/valid stream.
// A burst is only issued once FIFO room for all of its words is guaranteed
// (depth - fifo_count - outstanding), since readdatavalid cannot be stalled.
// Optional macro F2SDRAM_BURST_BOUNDARY_SPLIT_EN: when defined, bursts are
// also cut at MAX_BURST-aligned address boundaries.
module f2sdram_burst_reader #(
    parameter int ADDRESS_WIDTH    = 29,
    parameter int DATA_WIDTH       = 64,
    parameter int BURSTCOUNT_WIDTH = 8,
    parameter int BYTEENABLE_WIDTH = 8,
    parameter int MAX_BURST        = 64,
    parameter int LENGTH_WIDTH     = 16,
    parameter int FIFO_DEPTH_LOG2  = 7
) (
    input  logic                    clk,
    input  logic                    rst_req_sync,
    f2sdram_burst_reader_if.master  bus
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;   // counters reach DEPTH

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t                      state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
    logic [LENGTH_WIDTH-1:0]     rem_q, rem_d;
    logic [BURSTCOUNT_WIDTH-1:0] bcnt_q, bcnt_d;
    logic [CW-1:0]               outst_q, outst_d;
    logic [CW-1:0]               fcnt_q, fcnt_d;
    logic [FIFO_DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0]       mem [DEPTH];

    logic        accept, push, pop, drained, space_ok;
    logic [31:0] b_w, rem_w, room_w;
    logic [CW:0] free_w;

    // Bus handshakes; readdatavalid with nothing outstanding is stale
    // (left over from before a reset) and is dropped.
    assign accept  = (state_q == S_ISSUE) && !bus.waitrequest;
    assign push    = bus.readdatavalid && (outst_q != '0);
    assign pop     = (fcnt_q != '0) && bus.out_ready;
    assign drained = (outst_q == '0) && (fcnt_q == '0);

    // Next burst size and FIFO credit, both from registered state only.
    always_comb begin
        rem_w  = 32'(rem_q);
        room_w = 32'(MAX_BURST);
        b_w    = (rem_w < 32'(MAX_BURST)) ? rem_w : 32'(MAX_BURST);
`ifdef F2SDRAM_BURST_BOUNDARY_SPLIT_EN
        room_w = 32'(MAX_BURST) - (32'(addr_q) & (32'(MAX_BURST) - 32'd1));
        if (room_w < b_w) b_w = room_w;
`else
        room_w = 32'(MAX_BURST);
`endif
        free_w   = (CW+1)'(DEPTH) - {1'b0, fcnt_q} - {1'b0, outst_q};
        space_ok = (32'(free_w) >= b_w);
    end

    // Control FSM: next state, address, remaining length, burst size.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_address;
                    rem_d   = bus.req_length;
                    state_d = (bus.req_length == '0) ? S_DRAIN : S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (space_ok) begin
                    bcnt_d  = BURSTCOUNT_WIDTH'(b_w);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!bus.waitrequest) begin
                    addr_d  = addr_q + ADDRESS_WIDTH'(bcnt_q);
                    rem_d   = rem_q - LENGTH_WIDTH'(bcnt_q);
                    state_d = (rem_q == LENGTH_WIDTH'(bcnt_q)) ? S_DRAIN : S_WAIT_SPACE;
                end
            end
            S_DRAIN: begin
                if (drained) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outstanding-word and FIFO occupancy counters; simultaneous inc/dec both apply.
    always_comb begin
        outst_d = outst_q;
        if (accept) outst_d = outst_d + CW'(bcnt_q);
        if (push)   outst_d = outst_d - CW'(1);
        fcnt_d  = fcnt_q + CW'(push) - CW'(pop);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_req_sync) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            bcnt_q   <= BURSTCOUNT_WIDTH'(1);
            outst_q  <= '0;
            fcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            bcnt_q   <= bcnt_d;
            outst_q  <= outst_d;
            fcnt_q   <= fcnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.readdata;
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DRAIN) && drained;
    assign bus.read       = (state_q == S_ISSUE);
    assign bus.address    = addr_q;
    assign bus.burstcount = bcnt_q;
    assign bus.byteenable = '1;
    assign bus.out_valid  = (fcnt_q != '0);
    assign bus.out_data   = mem[rd_ptr_q];

    // Credit invariant: reserved plus stored words never exceed the FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst_req_sync)
        ({1'b0, fcnt_q} + {1'b0, outst_q}) <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_f2sdram_burst_reader.sv
// Self-checking bench for f2sdram_burst_reader: an Avalon memory responder
// returns a known per-address pattern, and scoreboards hold the expected
// bursts and stream words pushed when each request is driven.
module tb_f2sdram_burst_reader;
    localparam int AW = 29, DW = 64, BW = 8, BEW = 8, LW = 16, MAXB = 64, FDL = 7;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] n;
    } burst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    f2sdram_burst_reader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BW),
                              .BYTEENABLE_WIDTH(BEW), .LENGTH_WIDTH(LW)) bus ();

    f2sdram_burst_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BW),
                           .BYTEENABLE_WIDTH(BEW), .MAX_BURST(MAXB), .LENGTH_WIDTH(LW),
                           .FIFO_DEPTH_LOG2(FDL)) dut (
        .clk          (clk),
        .rst_req_sync (rst),
        .bus          (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_bursts = 0;
    int n_done   = 0;
    logic [DW-1:0] exp_words[$];
    burst_t        exp_bursts[$];
    burst_t        pend[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {~32'(a), 32'(a)};
    endfunction

    // Independent split model: bursts and words expected for one request.
    task automatic push_expect(input logic [AW-1:0] addr, input int len);
        int            rem = len;
        int            b;
        logic [AW-1:0] a = addr;
        burst_t        eb;
        while (rem > 0) begin
            b = (rem < MAXB) ? rem : MAXB;
`ifdef F2SDRAM_BURST_BOUNDARY_SPLIT_EN
            if (MAXB - int'(a % MAXB) < b) b = MAXB - int'(a % MAXB);
`endif
            eb.a = a;
            eb.n = BW'(b);
            exp_bursts.push_back(eb);
            a   = a + AW'(b);
            rem = rem - b;
        end
        for (int i = 0; i < len; i++) exp_words.push_back(mem_word(addr + AW'(i)));
    endtask

    task automatic do_req(input logic [AW-1:0] addr, input int len);
        int t = 0;
        push_expect(addr, len);
        @(negedge clk);
        while (!bus.req_ready && t < 2000) begin @(negedge clk); t++; end
        chk("req_ready_wait", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid   = 1'b1;
        bus.req_address = addr;
        bus.req_length  = LW'(len);
        @(posedge clk); #1;
        bus.req_valid   = 1'b0;
    endtask

    task automatic finish_req(input string tag, input int base_done, input int budget);
        int t = 0;
        while (n_done == base_done && t < budget) begin @(negedge clk); t++; end
        chk({tag, "_done_seen"}, (n_done != base_done), 1);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_done_once"}, n_done - base_done, 1);
        chk({tag, "_busy_clr"}, bus.busy, 0);
        chk({tag, "_ready"}, bus.req_ready, 1);
        chk({tag, "_words_left"}, exp_words.size(), 0);
        chk({tag, "_bursts_left"}, exp_bursts.size(), 0);
    endtask

    // Monitor: accepted bursts, stream pops and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        burst_t        eb;
        logic [DW-1:0] ew;
        if (!rst) begin
            if (bus.read && !bus.waitrequest) begin
                n_bursts++;
                eb.a = bus.address;
                eb.n = bus.burstcount;
                pend.push_back(eb);
                if (exp_bursts.size() == 0) chk("burst_unexpected", exp_bursts.size(), 1);
                else begin
                    eb = exp_bursts.pop_front();
                    chk("burst_addr", bus.address, eb.a);
                    chk("burst_len", bus.burstcount, eb.n);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_words.size() == 0) chk("word_unexpected", exp_words.size(), 1);
                else begin
                    ew = exp_words.pop_front();
                    chk("word_data", bus.out_data, ew);
                end
            end
            if (bus.done) n_done++;
        end
    end

    // Avalon memory responder: returns pattern data for accepted bursts with random gaps.
    initial begin
        burst_t cur;
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
        forever begin
            @(posedge clk); #1;
            if (pend.size() != 0 && $urandom_range(0, 3) != 0) begin
                cur = pend.pop_front();
                bus.readdatavalid = 1'b1;
                bus.readdata      = mem_word(cur.a);
                cur.a = cur.a + 1'b1;
                cur.n = cur.n - 1'b1;
                if (cur.n != 0) pend.push_front(cur);
            end else begin
                bus.readdatavalid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bd, bb, t;
        bus.req_valid   = 1'b0;
        bus.req_address = '0;
        bus.req_length  = '0;
        bus.waitrequest = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_read", bus.read, 0);
        chk("rst_burstcount", bus.burstcount, 1);
        chk("rst_address", bus.address, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("byteenable", bus.byteenable, 8'hFF);
        @(posedge clk); #1 rst = 1'b0;

        // single short burst
        bd = n_done;
        do_req(29'h100, 10);
        finish_req("len10", bd, 500);

        // multi-burst split 64/64/22
        bd = n_done; bb = n_bursts;
        do_req(29'h0, 150);
        finish_req("len150", bd, 2000);
        chk("len150_nbursts", n_bursts - bb, 3);

        // zero length: done on the cycle after acceptance, no bus traffic
        bd = n_done; bb = n_bursts;
        do_req(29'h500, 0);
        @(negedge clk);
        chk("len0_done", bus.done, 1);
        @(negedge clk);
        chk("len0_done_drop", bus.done, 0);
        chk("len0_ready", bus.req_ready, 1);
        chk("len0_nbursts", n_bursts - bb, 0);

        // waitrequest stall: command held stable
        bd = n_done; bb = n_bursts;
        bus.waitrequest = 1'b1;
        do_req(29'h200, 10);
        t = 0;
        while (!bus.read && t < 50) begin @(negedge clk); t++; end
        for (int i = 0; i < 5; i++) begin
            chk("stall_read", bus.read, 1);
            chk("stall_addr", bus.address, 29'h200);
            chk("stall_bcnt", bus.burstcount, 10);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.waitrequest = 1'b0;
        finish_req("stall", bd, 500);
        chk("stall_nbursts", n_bursts - bb, 1);

        // unaligned start near a 64-word boundary
        bd = n_done;
        do_req(29'h3C, 10);
        finish_req("unaligned", bd, 500);

        // address wrap at 2**ADDRESS_WIDTH
        bd = n_done;
        do_req(29'h1FFF_FFFC, 8);
        finish_req("wrap", bd, 500);

        // back-pressure: credit limits issue to the FIFO depth
        bd = n_done; bb = n_bursts;
        bus.out_ready = 1'b0;
        do_req(29'h0, 300);
        repeat (200) @(negedge clk);
        chk("bp_two_bursts", n_bursts - bb, 2);
        chk("bp_read_idle", bus.read, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        repeat (64) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (100) @(negedge clk);
        chk("bp_three_bursts", n_bursts - bb, 3);
        chk("bp_read_idle2", bus.read, 0);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        finish_req("bp", bd, 3000);
        chk("bp_nbursts", n_bursts - bb, 5);

        // reset in the middle of a transfer
        bb = n_bursts;
        do_req(29'h2000, 150);
        t = 0;
        while (n_bursts == bb && t < 200) begin @(negedge clk); t++; end
        chk("rstmid_started", (n_bursts != bb), 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_read", bus.read, 0);
        chk("rstmid_out_valid", bus.out_valid, 0);
        chk("rstmid_busy", bus.busy, 0);
        chk("rstmid_ready", bus.req_ready, 1);
        exp_words.delete();
        exp_bursts.delete();
        @(posedge clk); #1 rst = 1'b0;
        t = 0;
        while (pend.size() != 0 && t < 500) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        chk("stale_drained", pend.size(), 0);
        chk("stale_dropped", bus.out_valid, 0);
        chk("stale_idle", bus.busy, 0);
        bd = n_done;
        do_req(29'h3000, 4);
        finish_req("post_rst", bd, 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
